// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared constants for the pipeline controller: stage slot indices,
// controller state encodings and the default PC width.
package pipe_ctrl_gen_pkg;

  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EXE = 2;
  localparam int STG_EXE_MEM = 3;
  localparam int STG_MEM_WB = 4;
  localparam int STG_WB     = 5;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_DRAIN  = 2'd1,
    PC_HALTED = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_gen_perf_cnt.sv
// Saturating, enable-gated event counter used for pipeline performance
// statistics; holds at all-ones instead of wrapping.
module pipe_perf_cnt
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);
  import pipe_ctrl_gen_pkg::*;

  logic [WIDTH-1:0] cnt_r;

  // Count enabled cycles, sticking at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != {WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush/redirect controller with halt drain.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_gen
#(
  parameter int STAGES         = 6,
  parameter int REDIRECT_STAGE = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [STAGES-1:0]     stallreq_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  trap_i,
  input  logic [ADDR_WIDTH-1:0] trap_vec_i,
  input  logic                  halt_req_i,
  output logic [STAGES-1:0]     stall_o,
  output logic [STAGES-1:0]     flush_o,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  halted_o,
  output logic [CNT_WIDTH-1:0]  stall_cycles_o,
  output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);
  import pipe_ctrl_gen_pkg::*;

  localparam int CW = (STAGES > 2) ? $clog2(STAGES) : 1;

  pc_state_e             state_r, next_state_s;
  logic [CW-1:0]         drain_cnt_r, drain_cnt_n;
  logic                  pend_v_r, pend_v_n;
  logic [ADDR_WIDTH-1:0] pend_pc_r, pend_pc_n;

  logic                  any_req_s;
  int                    hi_s;
  logic                  frozen_s;
  logic                  redir_req_s;
  logic [ADDR_WIDTH-1:0] target_s;

  logic [STAGES-1:0]     stall_s, flush_s;
  logic                  redirect_s;
  logic [ADDR_WIDTH-1:0] new_pc_s;

  // Highest-index stall request decides how far back the pipeline freezes.
  always_comb begin
    any_req_s = |stallreq_i;
    hi_s      = 0;
    for (int i = 0; i < STAGES; i++) begin
      if (stallreq_i[i]) begin
        hi_s = i;
      end else begin
        hi_s = hi_s;
      end
    end
  end

  assign frozen_s    = any_req_s && (hi_s >= REDIRECT_STAGE);
  assign redir_req_s = trap_i | jump_enable_i;
  assign target_s    = trap_i ? trap_vec_i : jump_addr_i;

  // Next-state, pending-redirect bookkeeping and stall/flush/redirect decode.
  always_comb begin
    next_state_s = state_r;
    drain_cnt_n  = drain_cnt_r;
    pend_v_n     = pend_v_r;
    pend_pc_n    = pend_pc_r;
    redirect_s   = 1'b0;
    new_pc_s     = '0;
    for (int i = 0; i < STAGES; i++) begin
      stall_s[i] = any_req_s && (i <= hi_s);
      flush_s[i] = any_req_s && (i == hi_s + 1);
    end

    case (state_r)
      PC_RUN: begin
        if (frozen_s) begin
          // Resolving stage is held: park the target; only a trap may replace it.
          if (trap_i) begin
            pend_v_n  = 1'b1;
            pend_pc_n = trap_vec_i;
          end else if (jump_enable_i && !pend_v_r) begin
            pend_v_n  = 1'b1;
            pend_pc_n = jump_addr_i;
          end else begin
            pend_v_n  = pend_v_r;
          end
        end else if (redir_req_s || pend_v_r) begin
          redirect_s = 1'b1;
          if (trap_i) begin
            new_pc_s = trap_vec_i;
          end else if (pend_v_r) begin
            new_pc_s = pend_pc_r;
          end else begin
            new_pc_s = jump_addr_i;
          end
          pend_v_n = 1'b0;
          for (int i = 0; i < REDIRECT_STAGE; i++) stall_s[i] = 1'b0;
          for (int i = 1; i < REDIRECT_STAGE; i++) flush_s[i] = 1'b1;
        end else begin
          pend_v_n = pend_v_r;
        end

        if (halt_req_i) begin
          next_state_s = PC_DRAIN;
          drain_cnt_n  = CW'(STAGES - 1);
        end else begin
          next_state_s = PC_RUN;
        end
      end

      PC_DRAIN: begin
        pend_v_n = 1'b0;
        if (redir_req_s && !frozen_s) begin
          for (int i = 0; i < REDIRECT_STAGE; i++) stall_s[i] = 1'b0;
          for (int i = 1; i < REDIRECT_STAGE; i++) flush_s[i] = 1'b1;
        end else begin
          redirect_s = 1'b0;
        end
        // Fetch stays frozen and a bubble follows it down the pipe.
        stall_s[STG_PC]    = 1'b1;
        flush_s[STG_IF_ID] = 1'b1;

        if (!stall_s[STG_IF_ID]) begin
          if (drain_cnt_r <= CW'(1)) begin
            next_state_s = PC_HALTED;
            drain_cnt_n  = '0;
          end else begin
            drain_cnt_n  = drain_cnt_r - CW'(1);
          end
        end else begin
          drain_cnt_n = drain_cnt_r;
        end
      end

      PC_HALTED: begin
        stall_s  = '1;
        flush_s  = '0;
        pend_v_n = 1'b0;
      end

      default: begin
        next_state_s = PC_RUN;
        pend_v_n     = 1'b0;
      end
    endcase
  end

  // Controller state, drain counter and parked redirect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= PC_RUN;
      drain_cnt_r <= '0;
      pend_v_r    <= 1'b0;
      pend_pc_r   <= '0;
    end else begin
      state_r     <= next_state_s;
      drain_cnt_r <= drain_cnt_n;
      pend_v_r    <= pend_v_n;
      pend_pc_r   <= pend_pc_n;
    end
  end

  // Combinational outputs read as zero while reset is held.
  assign stall_o    = stall_s & {STAGES{rst_i}};
  assign flush_o    = flush_s & {STAGES{rst_i}};
  assign redirect_o = redirect_s & rst_i;
  assign new_pc_o   = new_pc_s & {ADDR_WIDTH{rst_i}};
  assign halted_o   = (state_r == PC_HALTED);

`ifdef PIPE_PERF_CNT_EN
  logic stall_cnt_en_s;

  assign stall_cnt_en_s = (|stall_o) && ((state_r == PC_RUN) || (state_r == PC_DRAIN));

  pipe_perf_cnt #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (stall_cnt_en_s),
    .cnt   (stall_cycles_o)
  );

  pipe_perf_cnt #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (redirect_o),
    .cnt   (redirect_cnt_o)
  );
`else
  assign stall_cycles_o = {CNT_WIDTH{1'b0}};
  assign redirect_cnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: a vector table for the combinational
// stall/flush/redirect decode plus sequences for pending redirects and halt drain.
module tb_pipe_ctrl_gen;

  logic        clk;
  logic        rst_i;
  logic [5:0]  stallreq_i;
  logic        jump_enable_i;
  logic [31:0] jump_addr_i;
  logic        trap_i;
  logic [31:0] trap_vec_i;
  logic        halt_req_i;
  logic [5:0]  stall_o;
  logic [5:0]  flush_o;
  logic        redirect_o;
  logic [31:0] new_pc_o;
  logic        halted_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] redirect_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS = 32'd10;
  localparam logic [31:0] EXP_REDIRS = 32'd2;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_REDIRS = 32'd0;
`endif

  pipe_ctrl_gen dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .stallreq_i     (stallreq_i),
    .jump_enable_i  (jump_enable_i),
    .jump_addr_i    (jump_addr_i),
    .trap_i         (trap_i),
    .trap_vec_i     (trap_vec_i),
    .halt_req_i     (halt_req_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .redirect_o     (redirect_o),
    .new_pc_o       (new_pc_o),
    .halted_o       (halted_o),
    .stall_cycles_o (stall_cycles_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [5:0]  req;
    logic        jmp;
    logic [31:0] jaddr;
    logic        trp;
    logic [31:0] tvec;
    logic [5:0]  e_stall;
    logic [5:0]  e_flush;
    logic        e_redir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stallreq_i    = 6'b000000;
    jump_enable_i = 1'b0;
    jump_addr_i   = 32'h0;
    trap_i        = 1'b0;
    trap_vec_i    = 32'h0;
    halt_req_i    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0;
    idle_inputs();

    vecs[0] = '{6'b000000, 1'b0, 32'h0,   1'b0, 32'h0,  6'b000000, 6'b000000, 1'b0, 32'h0};
    vecs[1] = '{6'b000100, 1'b0, 32'h0,   1'b0, 32'h0,  6'b000111, 6'b001000, 1'b0, 32'h0};
    vecs[2] = '{6'b000001, 1'b0, 32'h0,   1'b0, 32'h0,  6'b000001, 6'b000010, 1'b0, 32'h0};
    vecs[3] = '{6'b100000, 1'b0, 32'h0,   1'b0, 32'h0,  6'b111111, 6'b000000, 1'b0, 32'h0};
    vecs[4] = '{6'b010010, 1'b0, 32'h0,   1'b0, 32'h0,  6'b011111, 6'b100000, 1'b0, 32'h0};
    vecs[5] = '{6'b000000, 1'b1, 32'h100, 1'b1, 32'h8,  6'b000000, 6'b000110, 1'b1, 32'h8};
    vecs[6] = '{6'b000000, 1'b1, 32'h40,  1'b0, 32'h0,  6'b000000, 6'b000110, 1'b1, 32'h40};
    vecs[7] = '{6'b000010, 1'b1, 32'h80,  1'b0, 32'h0,  6'b000000, 6'b000110, 1'b1, 32'h80};
    vecs[8] = '{6'b000100, 1'b0, 32'h0,   1'b1, 32'h1C, 6'b000000, 6'b001110, 1'b1, 32'h1C};
    vecs[9] = '{6'b001000, 1'b0, 32'h0,   1'b0, 32'h0,  6'b001111, 6'b010000, 1'b0, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stall", stall_o, 6'b000000);
    check("rst_flush", flush_o, 6'b000000);
    check("rst_redirect", redirect_o, 1'b0);
    check("rst_new_pc", new_pc_o, 32'h0);
    check("rst_halted", halted_o, 1'b0);
    check("rst_stall_cnt", stall_cycles_o, 32'h0);
    check("rst_redir_cnt", redirect_cnt_o, 32'h0);
    rst_i = 1'b1;

    // Performance counters: 10 stalled cycles then 2 jumps
    tick();
    stallreq_i = 6'b000001;
    repeat (10) tick();
    stallreq_i    = 6'b000000;
    jump_enable_i = 1'b1;
    jump_addr_i   = 32'h10;
    repeat (2) tick();
    idle_inputs();
    #1;
    check("perf_stall_cycles", stall_cycles_o, EXP_STALLS);
    check("perf_redirect_cnt", redirect_cnt_o, EXP_REDIRS);

    // Combinational decode table
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      stallreq_i    = vecs[v].req;
      jump_enable_i = vecs[v].jmp;
      jump_addr_i   = vecs[v].jaddr;
      trap_i        = vecs[v].trp;
      trap_vec_i    = vecs[v].tvec;
      #1;
      check($sformatf("vec%0d_stall", v), stall_o, vecs[v].e_stall);
      check($sformatf("vec%0d_flush", v), flush_o, vecs[v].e_flush);
      check($sformatf("vec%0d_redirect", v), redirect_o, vecs[v].e_redir);
      if (vecs[v].e_redir) check($sformatf("vec%0d_new_pc", v), new_pc_o, vecs[v].e_pc);
    end
    @(negedge clk);
    idle_inputs();

    // Jump while slot 4 is frozen for 3 cycles, applied on release
    tick();
    stallreq_i    = 6'b010000;
    jump_enable_i = 1'b1;
    jump_addr_i   = 32'h200;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("pend_hold%0d_redirect", c), redirect_o, 1'b0);
      tick();
      jump_enable_i = 1'b0;
    end
    stallreq_i = 6'b000000;
    #1;
    check("pend_release_redirect", redirect_o, 1'b1);
    check("pend_release_new_pc", new_pc_o, 32'h200);
    check("pend_release_flush", flush_o, 6'b000110);
    tick();
    check("pend_cleared_redirect", redirect_o, 1'b0);

    // Trap overwrites a parked jump; a later jump does not
    stallreq_i    = 6'b001000;
    jump_enable_i = 1'b1;
    jump_addr_i   = 32'h300;
    tick();
    jump_enable_i = 1'b0;
    trap_i        = 1'b1;
    trap_vec_i    = 32'h44;
    tick();
    trap_i        = 1'b0;
    jump_enable_i = 1'b1;
    jump_addr_i   = 32'h500;
    #1;
    check("pend_frozen_redirect", redirect_o, 1'b0);
    tick();
    idle_inputs();
    #1;
    check("pend_trap_redirect", redirect_o, 1'b1);
    check("pend_trap_new_pc", new_pc_o, 32'h44);
    tick();

    // Halt drain with a second pulse ignored mid-drain
    halt_req_i = 1'b1;
    tick();
    halt_req_i = 1'b0;
    check("drain_stall", stall_o, 6'b000001);
    check("drain_flush", flush_o, 6'b000010);
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) halt_req_i = 1'b1;
      tick();
      halt_req_i = 1'b0;
      #1;
      check($sformatf("drain1_c%0d_halted", c), halted_o, (c == 5));
    end
    check("halted_stall", stall_o, 6'b111111);
    check("halted_flush", flush_o, 6'b000000);
    jump_enable_i = 1'b1;
    jump_addr_i   = 32'h900;
    stallreq_i    = 6'b000100;
    #1;
    check("halted_jump_redirect", redirect_o, 1'b0);
    check("halted_req_flush", flush_o, 6'b000000);
    tick();
    idle_inputs();
    check("halted_sticky", halted_o, 1'b1);

    // Reset pulled mid-drain, then a fresh drain with a jump inside it
    do_reset();
    halt_req_i = 1'b1;
    tick();
    halt_req_i = 1'b0;
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    check("mid_rst_stall", stall_o, 6'b000000);
    check("mid_rst_flush", flush_o, 6'b000000);
    check("mid_rst_redirect", redirect_o, 1'b0);
    check("mid_rst_halted", halted_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    halt_req_i = 1'b1;
    tick();
    halt_req_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 1) begin
        jump_enable_i = 1'b1;
        jump_addr_i   = 32'h700;
        #1;
        check("drain_jump_redirect", redirect_o, 1'b0);
        check("drain_jump_flush", flush_o, 6'b000110);
        check("drain_jump_stall", stall_o, 6'b000001);
      end
      tick();
      jump_enable_i = 1'b0;
      #1;
      check($sformatf("drain2_c%0d_halted", c), halted_o, (c == 5));
    end

    // Drain counter pauses while slot 1 is stalled
    do_reset();
    tick();
    halt_req_i = 1'b1;
    tick();
    halt_req_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      stallreq_i = (c <= 2) ? 6'b000010 : 6'b000000;
      if (c == 1) begin
        #1;
        check("drain_stall1_stall", stall_o, 6'b000011);
        check("drain_stall1_flush", flush_o, 6'b000110);
      end
      tick();
      #1;
      check($sformatf("drain3_c%0d_halted", c), halted_o, (c == 7));
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
